// File: rtl/param_memory.sv
// Single-port synchronous data memory with byte-lane writes, a registered read port,
// address range checking and an optional post-reset zero-fill sequencer.
module param_memory #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned SCRUB      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic                    rw,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    err
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1   = ADDR_WIDTH + 1;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [0:0] RESET_STATE = (SCRUB != 0) ? INIT : RUN;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [AW1-1:0]   DEPTH_EXT = AW1'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [IDX_W-1:0]      cnt;
    logic [IDX_W-1:0]      cnt_next;
    logic                  ready_next;
    logic [DATA_WIDTH-1:0] dout_next;
    logic                  dout_valid_next;
    logic                  err_next;

    logic                  accept_c;
    logic                  in_range_c;
    logic                  scrub_we_c;
    logic                  wr_we_c;
    logic [IDX_W-1:0]      idx_c;

    // Registered state and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RESET_STATE;
            cnt        <= '0;
            ready      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ready      <= ready_next;
            dout       <= dout_next;
            dout_valid <= dout_valid_next;
            err        <= err_next;
        end
    end

    // Next-state, request decode and output next values
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        ready_next      = 1'b0;
        dout_next       = dout;
        dout_valid_next = 1'b0;
        err_next        = 1'b0;
        scrub_we_c      = 1'b0;
        wr_we_c         = 1'b0;

        // Widened compare so DEPTH == 2**ADDR_WIDTH does not overflow
        in_range_c = ({1'b0, addr} < DEPTH_EXT);
        idx_c      = IDX_W'(addr);
        accept_c   = valid && ready;

        case (state)
            INIT: begin
                scrub_we_c = reset;
                cnt_next   = cnt + IDX_W'(1);
                if (cnt == LAST_IDX) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase

        ready_next = (state_next == RUN);

        if (accept_c) begin
            err_next = !in_range_c;
            if (rw) begin
                wr_we_c = in_range_c;
            end else begin
                dout_valid_next = 1'b1;
                dout_next       = in_range_c ? mem[idx_c] : '0;
            end
        end
    end

    // Storage: scrub fill takes precedence; ready is low while scrubbing so they never collide
    always_ff @(posedge clk) begin
        if (scrub_we_c) begin
            mem[cnt] <= '0;
        end else if (wr_we_c) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) begin
                    mem[idx_c][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

endmodule
